// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
//   state_t          - control FSM states (RUN / HALTED / ERROR)
//   PC_STEP          - sequential PC increment in bytes
//   DEFAULT_RESET_PC - default PC loaded on reset
package pc_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC selection and alignment check.
//   pc         in  current PC
//   alu_out    in  ALU result; bit 0 = branch condition, word = jump target
//   br_imm     in  signed branch offset in words
//   is_br      in  conditional branch
//   is_jal     in  jump-and-link
//   pc_plus4   out pc + 4 (link value / sequential target)
//   target     out selected target: jal > taken branch > sequential
//   redirect   out jal or taken-branch path selected
//   misaligned out target[1:0] != 0
module next_pc_calc
  import pc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] br_imm,
  input  logic        is_br,
  input  logic        is_jal,
  output logic [31:0] pc_plus4,
  output logic [31:0] target,
  output logic        redirect,
  output logic        misaligned
);

  logic [31:0] br_target;

  // All arithmetic wraps modulo 2^32; the 32-bit result width truncates.
  assign pc_plus4  = pc + PC_STEP;
  assign br_target = pc_plus4 + (br_imm << 2);

  always_comb begin
    target   = pc_plus4;
    redirect = 1'b0;
    if (is_jal) begin
      target   = alu_out;
      redirect = 1'b1;
    end else if (is_br && alu_out[0]) begin
      target   = br_target;
      redirect = 1'b1;
    end
  end

  assign misaligned = |target[1:0];

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with RUN/HALTED/ERROR control FSM.
//   clk          in  rising-edge clock
//   reset        in  synchronous active-high reset
//   alu_out      in  branch condition (bit 0) / jump target
//   is_br        in  conditional branch
//   is_jal       in  jump-and-link
//   br_imm       in  signed branch offset in words
//   stall        in  hold PC this cycle (beats halt and error detection)
//   halt_req     in  HALT instruction
//   pc           out registered current PC
//   pc_plus4     out pc + 4 (combinational)
//   taken        out redirect selected this cycle (combinational)
//   halted       out FSM in HALTED
//   misalign_err out FSM in ERROR
//   retired      out number of PC advances since reset (wraps)
module pc_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_out,
  input  logic        is_br,
  input  logic        is_jal,
  input  logic [31:0] br_imm,
  input  logic        stall,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        taken,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] retired
);

  state_t      state, state_nxt;
  logic [31:0] target;
  logic        redirect, misaligned;
  logic        active;
  logic        load;

  next_pc_calc u_calc (
    .pc         (pc),
    .alu_out    (alu_out),
    .br_imm     (br_imm),
    .is_br      (is_br),
    .is_jal     (is_jal),
    .pc_plus4   (pc_plus4),
    .target     (target),
    .redirect   (redirect),
    .misaligned (misaligned)
  );

  // RUN with neither stall nor halt: the only case where a target is acted on.
  assign active = (state == ST_RUN) && !stall && !halt_req;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Next-state logic; HALTED and ERROR only leave through reset.
  always_comb begin
    state_nxt = state;
    if (state == ST_RUN && !stall) begin
      if (halt_req)        state_nxt = ST_HALTED;
      else if (misaligned) state_nxt = ST_ERROR;
    end
  end

  // Outputs. Status flags are forced low while reset is asserted so the
  // previous state is not visible during the reset cycle.
  always_comb begin
    load         = active && !misaligned;
    taken        = !reset && active && redirect;
    halted       = !reset && (state == ST_HALTED);
    misalign_err = !reset && (state == ST_ERROR);
  end

  // PC register and retire counter; reset discards any pending redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      retired <= 32'd0;
    end else if (load) begin
      pc      <= target;
      retired <= retired + 32'd1;
    end
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have port clk  input  1  rising-edge system clock.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port alu_out  input  32  ALU result; bit 0 is the branch condition, and the full word is the jump target.
REQ-005 The block SHALL have port is_br  input  1  current instruction is a conditional branch.
REQ-006 The block SHALL have port is_jal  input  1  current instruction is jump-and-link, with target equal to alu_out.
REQ-007 The block SHALL have port br_imm  input  32  signed branch offset in words.
REQ-008 The block SHALL have port stall  input  1  hold the PC this cycle.
REQ-009 The block SHALL have port halt_req  input  1  current instruction is HALT.
REQ-010 The block SHALL have port pc  output  32  registered address of the current instruction.
REQ-011 The block SHALL have port pc_plus4  output  32  pc+4, used as the link value; combinational.
REQ-012 The block SHALL have port taken  output  1  a redirect is selected this cycle; combinational.
REQ-013 The block SHALL have port halted  output  1  the FSM is in HALTED.
REQ-014 The block SHALL have port misalign_err  output  1  the FSM is in ERROR.
REQ-015 The block SHALL have port retired  output  32  count of PC advances since reset.

Function
REQ-016 The FSM SHALL have exactly three states: RUN, HALTED and ERROR.
REQ-017 In RUN, the next PC SHALL be selected by priority: stall (hold) > halt_req (hold, go to HALTED) > is_jal (alu_out) > is_br&&alu_out[0] (branch target) > sequential (pc+4).
REQ-018 The branch target SHALL be pc+4+(br_imm<<2), computed modulo 2^32.
REQ-019 The sequential next PC SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 with no flag.
REQ-020 When is_br and is_jal are both high, jal SHALL win.
REQ-021 taken SHALL be 1 only in RUN, with stall=0 and halt_req=0, when the jal or taken-branch path is selected.
REQ-022 The new PC SHALL appear on pc exactly one clock after the selecting cycle, so redirect latency is 1 cycle.
REQ-023 If the selected target has bits [1:0] != 0, the block SHALL hold pc unchanged and enter ERROR.
REQ-024 HALTED and ERROR SHALL be absorbing: pc holds, retired holds, taken=0, and all inputs are ignored until reset.
REQ-025 retired SHALL increment by 1 on each edge where pc is loaded with a new value in RUN, and SHALL wrap at 2^32.
REQ-026 stall SHALL take precedence over halt_req and error detection, with no state change while stall=1.
REQ-027 pc_plus4 SHALL equal pc+4 in every state.

Reset
REQ-028 On a clock edge with reset=1, the block SHALL set pc=RESET_PC, state=RUN, and retired=0, regardless of the current state or other inputs.
REQ-029 During reset, the block SHALL drive halted=0 and misalign_err=0; taken SHALL be 0 while reset=1.
REQ-030 Reset asserted mid-redirect SHALL discard the redirect.

Structure
REQ-031 The state enum and PC_STEP=4 SHALL live in shared package pc_pkg, and the default RESET_PC constant SHALL also live there.
REQ-032 The target arithmetic and alignment check SHALL be one combinational sub-module, next_pc_calc; the FSM, PC register and counter SHALL stay in pc_unit.

Verification
REQ-033 Sequential and wrap: reset with RESET_PC=32'hFFFF_FFF8 -> pc follows FFFF_FFF8, FFFF_FFFC, 0000_0000; retired=2.
REQ-034 Branch: pc=0x100, is_br=1, alu_out=1, br_imm=-2 -> taken=1, and next pc=0x0FC; with alu_out=0 -> next pc=0x104.
REQ-035 Jal priority: is_jal=1, is_br=1, alu_out=32'h0000_2000 -> next pc=0x2000; then alu_out=32'h2002 -> pc holds, misalign_err=1.
REQ-036 Stall/halt: stall=1 with halt_req=1 for 3 cycles -> pc and retired unchanged, halted=0; then stall=0 -> halted=1, and pc is frozen thereafter.
REQ-037 Reset out of HALTED/ERROR: reset for 1 cycle -> pc=RESET_PC, halted=0, misalign_err=0, retired=0.
